// File: rtl/crc16_pkg.sv
// crc16_pkg: shared constants, FSM state type and single-bit LFSR step for the
// serial CRC-16 generator/checker pair.
package crc16_pkg;

   localparam int          CRC16_W       = 16;
   localparam int          CRC16_DATA_W  = 34;
   localparam int          CRC16_FRAME_W = CRC16_DATA_W + CRC16_W;  // 50
   localparam logic [15:0] CRC16_POLY    = 16'hBAAD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } crc16_state_e;

   // One MSB-first division step: shift the bit in at the bottom, and fold the
   // polynomial back in when the top bit falls out.
   function automatic logic [15:0] crc16_step(input logic [15:0] lfsr, input logic bit_in);
      logic fb;
      fb = lfsr[15];
      return {lfsr[14:0], bit_in} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_serial_checker_if.sv
// crc16_serial_checker_if: codeword input handshake and result bus of the
// serial CRC-16 checker. The master drives codewords, the slave is the checker.
interface crc16_serial_checker_if
   import crc16_pkg::*;
#(
   parameter int DATA_W = CRC16_DATA_W,
   parameter int CRC_W  = CRC16_W
) ();

   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W+CRC_W-1:0]  codeword_in;
   logic                     out_valid;
   logic [DATA_W-1:0]        data_out;
   logic [CRC_W-1:0]         crc_rx;
   logic [CRC_W-1:0]         syndrome;
   logic                     crc_ok;

   modport master (
      output in_valid, codeword_in,
      input  in_ready, out_valid, data_out, crc_rx, syndrome, crc_ok
   );

   modport slave (
      input  in_valid, codeword_in,
      output in_ready, out_valid, data_out, crc_rx, syndrome, crc_ok
   );

endinterface

// File: rtl/crc16_lfsr_serial.sv
// crc16_lfsr_serial: bit-serial CRC-16 LFSR register, one bit per enabled cycle.
// Shared between the serial generator and checker.
module crc16_lfsr_serial
   import crc16_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic               bit_in,
   output logic [CRC16_W-1:0] state
);

   // LFSR register: clear wins over enable so a new frame always starts from 0
   always_ff @(posedge clk) begin
      if (reset || clear)
         state <= '0;
      else if (enable)
         state <= crc16_step(state, bit_in);
   end

endmodule

// File: rtl/crc16_serial_checker.sv
// crc16_serial_checker: takes a 50-bit {payload, crc} codeword, runs it MSB-first
// through the CRC-16 LFSR over 50 cycles, and reports payload, received CRC,
// residual syndrome and crc_ok for one cycle in DONE.
// Optional feature macro: CRC16_CHECK_ERRCNT_EN adds a saturating err_count output.
module crc16_serial_checker
   import crc16_pkg::*;
#(
   parameter int DATA_W = CRC16_DATA_W,
   parameter int CRC_W  = CRC16_W
) (
   input  logic                  clk,
   input  logic                  reset,
   crc16_serial_checker_if.slave bus
`ifdef CRC16_CHECK_ERRCNT_EN
   ,
   output logic [15:0]           err_count
`endif
);

   localparam int FRAME_W = DATA_W + CRC_W;

   crc16_state_e       state_q, state_d;
   logic [FRAME_W-1:0] shreg_q;
   logic [FRAME_W-1:0] shreg_rot;
   logic [5:0]         cnt_q;
   logic [CRC_W-1:0]   lfsr_q;
   logic [CRC_W-1:0]   syn_final;
   logic               take;
   logic               shifting;
   logic               last_bit;

   logic [DATA_W-1:0]  data_q;
   logic [CRC_W-1:0]   crc_q;
   logic [CRC_W-1:0]   syn_q;
   logic               ok_q;

   assign take      = bus.in_valid && (state_q == ST_IDLE);
   assign shifting  = (state_q == ST_SHIFT);
   assign last_bit  = shifting && (cnt_q == 6'(FRAME_W - 1));

   // The MSB is fed each cycle; rotating rather than discarding it means the
   // frame is back in its original position after 50 steps, so the payload and
   // CRC fields can be reported without a second 50-bit holding register.
   assign shreg_rot = {shreg_q[FRAME_W-2:0], shreg_q[FRAME_W-1]};

   // Syndrome including the bit being fed this cycle (value the LFSR lands on)
   assign syn_final = crc16_step(lfsr_q, shreg_q[FRAME_W-1]);

   crc16_lfsr_serial u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .clear  (take),
      .enable (shifting),
      .bit_in (shreg_q[FRAME_W-1]),
      .state  (lfsr_q)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next state and handshake outputs
   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid)
               state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (last_bit)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame shift register and bit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (take) begin
         shreg_q <= bus.codeword_in;
         cnt_q   <= '0;
      end else if (shifting) begin
         shreg_q <= shreg_rot;
         cnt_q   <= cnt_q + 6'd1;
      end
   end

   // Result registers: loaded as the last bit is fed, held until the next frame
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         crc_q  <= '0;
         syn_q  <= '0;
         ok_q   <= 1'b0;
      end else if (last_bit) begin
         data_q <= shreg_rot[FRAME_W-1:CRC_W];
         crc_q  <= shreg_rot[CRC_W-1:0];
         syn_q  <= syn_final;
         ok_q   <= (syn_final == '0);
      end
   end

   assign bus.data_out = data_q;
   assign bus.crc_rx   = crc_q;
   assign bus.syndrome = syn_q;
   assign bus.crc_ok   = ok_q;

`ifdef CRC16_CHECK_ERRCNT_EN
   logic [15:0] err_cnt_q;

   // Count failed frames as they are reported, sticking at all-ones
   always_ff @(posedge clk) begin
      if (reset)
         err_cnt_q <= '0;
      else if ((state_q == ST_DONE) && !ok_q && (err_cnt_q != 16'hFFFF))
         err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_serial_checker.sv
// tb_crc16_serial_checker: table-driven vectors plus hand-written sequences
// (in_valid held high, reset mid-frame, optional error counter). Expected
// results are queued at capture and compared when out_valid pulses.
module tb_crc16_serial_checker;

   logic clk;
   logic reset;

   crc16_serial_checker_if #(.DATA_W(34), .CRC_W(16)) bus ();

`ifdef CRC16_CHECK_ERRCNT_EN
   logic [15:0] err_count;
`endif

   crc16_serial_checker #(.DATA_W(34), .CRC_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus)
`ifdef CRC16_CHECK_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [49:0] cw;
      logic [15:0] syn;
      logic        ok;
   } vec_t;

   typedef struct {
      logic [33:0] data;
      logic [15:0] crc;
      logic [15:0] syn;
      logic        ok;
      int          cap;
   } exp_t;

   exp_t sb[$];
   vec_t vec[8];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   n_pushed = 0;
   int   ov_seen  = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain polynomial long division by x^16 + 0xBAAD
   function automatic logic [15:0] mod_g(input logic [49:0] cw);
      logic [49:0] r;
      r = cw;
      for (int i = 49; i >= 16; i--)
         if (r[i]) r = r ^ (50'h1BAAD << (i - 16));
      return r[15:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [49:0] cw, input logic [15:0] syn, input logic ok);
      exp_t e;
      e.data = cw[49:16];
      e.crc  = cw[15:0];
      e.syn  = syn;
      e.ok   = ok;
      e.cap  = cyc;
      sb.push_back(e);
      n_pushed++;
   endtask

   // Present a codeword, wait for acceptance, queue its expected result
   task automatic send(input logic [49:0] cw, input logic [15:0] syn, input logic ok);
      int t;
      t = 0;
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.codeword_in = cw;
      while (!bus.in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) begin
         chk("send_timeout", 64'(t), 64'd0);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      push_exp(cw, syn, ok);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((sb.size() != 0 || !bus.in_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("idle_timeout", 64'(sb.size()), 64'd0);
   endtask

   // Scoreboard: every out_valid pulse must match the oldest queued frame
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.out_valid) begin
         ov_seen++;
         if (sb.size() == 0) begin
            chk("spurious_out_valid", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("data_out", 64'(bus.data_out), 64'(e.data));
            chk("crc_rx",   64'(bus.crc_rx),   64'(e.crc));
            chk("syndrome", 64'(bus.syndrome), 64'(e.syn));
            chk("crc_ok",   64'(bus.crc_ok),   64'(e.ok));
            chk("latency",  64'(cyc - e.cap),  64'd50);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish by %0d cycles", cyc);
      $fatal(1);
   end

   initial begin
      logic [33:0] p;
      logic [49:0] cw;
      logic [49:0] cwk;

      // Spec vectors with literal expectations, then model-derived ones
      vec[0] = '{50'h0, 16'h0000, 1'b1};
      vec[1] = '{{34'h1, 16'hBAAD}, 16'h0000, 1'b1};
      vec[2] = '{{34'h1, 16'hBAAC}, 16'h0001, 1'b0};
      vec[3] = '{{34'h1, 16'hBA8D}, 16'h0020, 1'b0};
      p = 34'h3_FFFF_FFFF;
      cw = {p, 16'h0};
      cw[15:0] = mod_g(cw);
      vec[4] = '{cw, 16'h0000, 1'b1};
      p = 34'({$urandom, $urandom});
      cw = {p, 16'h0};
      cw[15:0] = mod_g(cw);
      vec[5] = '{cw, 16'h0000, 1'b1};
      cw[20] = ~cw[20];
      vec[6] = '{cw, mod_g(cw), 1'b0};
      cw = 50'({$urandom, $urandom});
      vec[7] = '{cw, mod_g(cw), mod_g(cw) == 16'h0};

      bus.in_valid    = 1'b0;
      bus.codeword_in = '0;
      reset           = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_data_out",  64'(bus.data_out),  64'd0);
      chk("rst_crc_rx",    64'(bus.crc_rx),    64'd0);
      chk("rst_syndrome",  64'(bus.syndrome),  64'd0);
      chk("rst_crc_ok",    64'(bus.crc_ok),    64'd0);
`ifdef CRC16_CHECK_ERRCNT_EN
      chk("rst_err_count", 64'(err_count), 64'd0);
`endif

      // Table: frames sent as fast as the handshake allows (back-to-back)
      for (int i = 0; i < 8; i++) send(vec[i].cw, vec[i].syn, vec[i].ok);
      wait_idle();
      repeat (5) @(negedge clk);
      chk("hold_data_out", 64'(bus.data_out), 64'(vec[7].cw[49:16]));
      chk("hold_syndrome", 64'(bus.syndrome), 64'(vec[7].syn));

      // in_valid held high with a new codeword every cycle: only offsets
      // 0, 52 and 104 may be captured
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         cwk = {34'(k * 34'h1_2345_679), 16'(k * 16'h3C5B)};
         bus.in_valid    = 1'b1;
         bus.codeword_in = cwk;
         @(posedge clk);
         #1;
         if (k % 52 == 0) push_exp(cwk, mod_g(cwk), mod_g(cwk) == 16'h0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_idle();

      // Reset 20 cycles into a frame, with in_valid asserted during reset
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.codeword_in = vec[6].cw;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (20) @(negedge clk);
      reset           = 1'b1;
      bus.in_valid    = 1'b1;
      bus.codeword_in = vec[3].cw;
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
      chk("abort_data_out",  64'(bus.data_out),  64'd0);
      chk("abort_crc_rx",    64'(bus.crc_rx),    64'd0);
      chk("abort_syndrome",  64'(bus.syndrome),  64'd0);
      chk("abort_crc_ok",    64'(bus.crc_ok),    64'd0);
      repeat (60) @(negedge clk);
      send(vec[1].cw, vec[1].syn, vec[1].ok);
      wait_idle();

`ifdef CRC16_CHECK_ERRCNT_EN
      send(vec[2].cw, vec[2].syn, vec[2].ok);
      send(vec[3].cw, vec[3].syn, vec[3].ok);
      send(vec[6].cw, vec[6].syn, vec[6].ok);
      send(vec[1].cw, vec[1].syn, vec[1].ok);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("err_count_3", 64'(err_count), 64'd3);
      @(negedge clk);
      force dut.err_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.err_cnt_q;
      send(vec[2].cw, vec[2].syn, vec[2].ok);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("err_count_sat", 64'(err_count), 64'hFFFF);
`endif

      repeat (5) @(negedge clk);
      chk("out_valid_count", 64'(ov_seen), 64'(n_pushed));
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/crc16_serial_checker.md
# crc16_serial_checker

Serial CRC-16 checker: the receive-side counterpart of the team's serial CRC-16 generator. Accepts a 50-bit codeword (34-bit payload followed by a 16-bit CRC), shifts it MSB-first through a 16-bit LFSR, and reports the payload, the received CRC, the residual syndrome and a pass/fail flag. It sits after the link deserializer and ahead of payload consumers.

## Interface
- `DATA_W`, default 34: payload width.
- `CRC_W`, default 16: CRC width. Fixed at 16; the polynomial constant is 16-bit.
- `clk` input, 1 bit: single clock; all logic updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: a codeword is present on `codeword_in`.
- `in_ready` output, 1 bit: high only in IDLE; a transfer occurs when `in_valid && in_ready`.
- `codeword_in` input, 50 bits: `{payload[33:0], crc[15:0]}`.
- `out_valid` output, 1 bit: one-cycle pulse; the result fields below are valid.
- `data_out` output, 34 bits: captured payload, `codeword[49:16]`.
- `crc_rx` output, 16 bits: captured CRC, `codeword[15:0]`.
- `syndrome` output, 16 bits: final LFSR contents.
- `crc_ok` output, 1 bit: `syndrome == 16'h0000`.
- `err_count` output, 16 bits: present only with `CRC16_CHECK_ERRCNT_EN`.

## Operation
- **Polynomial and LFSR:**
  - Polynomial taps `CRC16_POLY = 16'hBAAD`. Tap bits 0, 2, 3, 5, 7, 9, 11, 12, 13 and 15 are set.
  - The LFSR initialises to 0. There is no final XOR and no reflection.
  - Per input bit `b`: `fb = lfsr[15]`, `lfsr[0] <= b ^ fb`, and for i = 1..15 `lfsr[i] <= lfsr[i-1] ^ (POLY[i] & fb)`.
  - After all 50 bits have been fed, the LFSR holds `codeword mod G`. A valid codeword therefore gives 0.
- **FSM IDLE:**
  - `in_ready` = 1.
  - On a transfer: latch `codeword_in` into the shift register, clear the LFSR, clear the bit counter, and go to SHIFT.
- **FSM SHIFT:**
  - Each cycle, feed `shreg[49]`, shift `shreg` left by one bit, and increment the 6-bit counter.
  - When the counter equals 49, that 50th bit is fed and the state goes to DONE.
- **FSM DONE:**
  - `out_valid` = 1 for exactly this cycle, then go to IDLE.
- **Result hold:** `data_out`, `crc_rx`, `syndrome` and `crc_ok` are registered. They update at the SHIFT→DONE edge and are held until the next DONE.
- **`in_valid` while not IDLE:** ignored; no capture and no queuing.
- **Reset:**
  - All state is cleared: state = IDLE, `out_valid` = 0, `data_out` = 0, `crc_rx` = 0, `syndrome` = 0, `crc_ok` = 0, `err_count` = 0, counter = 0.
  - Reset mid-SHIFT aborts the frame with no `out_valid`.
  - Reset has priority over a simultaneous `in_valid`.

## Timing
- Capture edge E0. Shift edges E1..E50. `out_valid` is high in the cycle after E50.
- `in_ready` is low from after E0 until after E51.
- Throughput: one codeword per 52 cycles. Back-to-back: the next capture can occur at E52.
- Latency from transfer to `out_valid`: 51 cycles.

## Configuration
- Macro: `CRC16_CHECK_ERRCNT_EN`.
- **Defined:**
  - Adds the `err_count` output, a 16-bit counter incremented at each DONE with `crc_ok` = 0.
  - It saturates at `16'hFFFF` and is cleared only by `reset`.
- **Undefined:** the port and the counter logic are absent. All other behaviour is identical.

## Structure
- **Shared package `crc16_pkg`:**
  - Constants: `CRC16_POLY`, `CRC16_W`, `CRC16_DATA_W`, `CRC16_FRAME_W` (50).
  - The FSM state typedef.
  - A function `crc16_step(lfsr, bit)`, shared with the generator.
- **One sub-module `crc16_lfsr_serial`:**
  - The LFSR register with inputs `clear`, `enable`, `bit_in` and output `state`.
  - It is reused by the generator.

## Test plan
- All-zero codeword `50'h0` → `out_valid` after 51 cycles; `syndrome` = `16'h0000`, `crc_ok` = 1, `data_out` = 0.
- Valid codeword: payload `34'h1`, crc `16'hBAAD` → `crc_ok` = 1, `syndrome` = 0, `data_out` = `34'h1`, `crc_rx` = `16'hBAAD`.
- Single-bit errors:
  - Payload `34'h1`, crc `16'hBAAC` → `crc_ok` = 0, `syndrome` = `16'h0001`.
  - Payload `34'h1`, crc `16'hBA8D` → `syndrome` = `16'h0020`.
- `in_valid` held high continuously → captures only when `in_ready` is high; `out_valid` pulses every 52 cycles; intervening codewords are not captured.
- `reset` asserted at shift cycle 20, then a valid frame is sent → no `out_valid` for the aborted frame; outputs read 0; the next frame checks correctly.
- With `CRC16_CHECK_ERRCNT_EN`: three bad frames and one good frame → `err_count` = 3. After forcing the counter to `16'hFFFF`, another bad frame leaves it at `16'hFFFF`.
